// File: rtl/icg_ctrl_pkg.sv
// ============================================================================
// Module   : icg_ctrl_pkg
// Purpose  : State encodings shared by the ICG enable controller and its bench
// Revision : 1.0
// ============================================================================
`default_nettype none

package icg_ctrl_pkg;

    localparam logic [1:0] c_st_off  = 2'b00;
    localparam logic [1:0] c_st_wake = 2'b01;
    localparam logic [1:0] c_st_on   = 2'b10;
    localparam logic [1:0] c_st_idle = 2'b11;

    typedef enum logic [1:0] {
        ST_OFF  = c_st_off,
        ST_WAKE = c_st_wake,
        ST_ON   = c_st_on,
        ST_IDLE = c_st_idle
    } icg_state_e;

endpackage

`default_nettype wire

// File: rtl/icg_ctrl_sat_cnt.sv
// ============================================================================
// Module   : icg_ctrl_sat_cnt
// Purpose  : Saturating up-counter with synchronous clear and increment enable
// Revision : 1.0
// ============================================================================
`default_nettype none

module icg_ctrl_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rn,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over increment; the count holds once it reaches all-ones.
    always_ff @(posedge clk) begin
        if (!rn) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + c_one;
        end
    end

    assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/icg_enable_ctrl.sv
// ============================================================================
// Module   : icg_enable_ctrl
// Purpose  : Wake/hysteresis sequencer driving E of a shared integrated clock gate
// Revision : 1.0
// ============================================================================
`default_nettype none

module icg_enable_ctrl
    import icg_ctrl_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int HYST_W   = 8,
    parameter int WAKE_CYC = 2,
    parameter int CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RN,
    input  logic [N_REQ-1:0]  req,
    input  logic              force_on,
    input  logic [HYST_W-1:0] hyst_val,
    input  logic              scan_te,
    input  logic              clr_cnt,
    output logic              en,
    output logic              te,
    output logic [N_REQ-1:0]  ack,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  on_cnt
);

    localparam logic [HYST_W-1:0] c_wake_init = HYST_W'(WAKE_CYC);
    localparam logic [HYST_W-1:0] c_one       = {{(HYST_W-1){1'b0}}, 1'b1};

    icg_state_e        r_state;
    logic [HYST_W-1:0] r_timer;
    logic              w_any_req;
    logic              w_on;

    assign w_any_req = (|req) | force_on;

    // One timer serves both the wake countdown and the idle hysteresis.
    always_ff @(posedge CLK) begin
        if (!RN) begin
            r_state <= ST_OFF;
            r_timer <= '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (w_any_req) begin
                        r_state <= ST_WAKE;
                        r_timer <= c_wake_init;
                    end
                end
                ST_WAKE: begin
                    r_timer <= r_timer - c_one;
                    if (r_timer == c_one) begin
                        r_state <= ST_ON;
                    end
                end
                ST_ON: begin
                    if (!w_any_req) begin
                        if (hyst_val == '0) begin
                            r_state <= ST_OFF;
                        end else begin
                            r_state <= ST_IDLE;
                            r_timer <= hyst_val;
                        end
                    end
                end
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state <= ST_ON;
                        r_timer <= '0;
                    end else if (r_timer == c_one) begin
                        r_state <= ST_OFF;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer - c_one;
                    end
                end
                default: begin
                    r_state <= ST_OFF;
                    r_timer <= '0;
                end
            endcase
        end
    end

    // E is a pure decode of the state register, so it only moves on a rising edge.
    assign en    = (r_state != ST_OFF);
    assign w_on  = (r_state == ST_ON);
    assign state = r_state;
    assign te    = scan_te;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ack
        assign ack[gi] = req[gi] & w_on;
    end

    icg_ctrl_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_on_cnt (
        .clk (CLK),
        .rn  (RN),
        .clr (clr_cnt),
        .inc (en),
        .cnt (on_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_icg_enable_ctrl.sv
// ============================================================================
// Module   : tb_icg_enable_ctrl
// Purpose  : Directed and randomized self-checking bench for icg_enable_ctrl
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_icg_enable_ctrl;
    import icg_ctrl_pkg::*;

    localparam int N_REQ    = 4;
    localparam int HYST_W   = 8;
    localparam int WAKE_CYC = 2;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rn;
    logic [N_REQ-1:0]  req;
    logic              force_on;
    logic [HYST_W-1:0] hyst_val;
    logic              scan_te;
    logic              clr_cnt;
    logic              en;
    logic              te;
    logic [N_REQ-1:0]  ack;
    logic [1:0]        state;
    logic [CNT_W-1:0]  on_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: gate running flag, remaining wake cycles, remaining hold cycles.
    bit m_running = 1'b0;
    int m_wake    = 0;
    int m_hold    = 0;
    int m_cnt     = 0;

    icg_enable_ctrl #(
        .N_REQ    (N_REQ),
        .HYST_W   (HYST_W),
        .WAKE_CYC (WAKE_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .CLK      (clk),
        .RN       (rn),
        .req      (req),
        .force_on (force_on),
        .hyst_val (hyst_val),
        .scan_te  (scan_te),
        .clr_cnt  (clr_cnt),
        .en       (en),
        .te       (te),
        .ack      (ack),
        .state    (state),
        .on_cnt   (on_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit any;
        any = (|req) || force_on;
        if (!rn) begin
            m_running = 1'b0;
            m_wake    = 0;
            m_hold    = 0;
            m_cnt     = 0;
        end else begin
            if (clr_cnt)                           m_cnt = 0;
            else if (m_running && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (!m_running) begin
                if (any) begin
                    m_running = 1'b1;
                    m_wake    = WAKE_CYC;
                end
            end else if (m_wake > 0) begin
                m_wake = m_wake - 1;
            end else if (m_hold > 0) begin
                if (any)              m_hold = 0;
                else if (m_hold == 1) begin m_hold = 0; m_running = 1'b0; end
                else                  m_hold = m_hold - 1;
            end else if (!any) begin
                if (hyst_val == 0) m_running = 1'b0;
                else               m_hold = int'(hyst_val);
            end
        end
    endtask

    function automatic logic [1:0] exp_state();
        if (!m_running)   return c_st_off;
        else if (m_wake > 0) return c_st_wake;
        else if (m_hold > 0) return c_st_idle;
        else              return c_st_on;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic go_off();
        req = '0; force_on = 1'b0; hyst_val = '0; clr_cnt = 1'b0;
        repeat (8) cycle();
    endtask

    task automatic test_reset();
        rn = 1'b0; req = 4'b1111; force_on = 1'b0; hyst_val = '0;
        scan_te = 1'b0; clr_cnt = 1'b0;
        cycle(); cycle();
        n_checks++; if (en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", en); end
        n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        n_checks++; if (state !== c_st_off) begin n_fail++; $display("FAIL reset_state: got %b expected %b", state, c_st_off); end
        n_checks++; if (on_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", on_cnt); end
        rn = 1'b1;
        cycle();
        n_checks++; if (state !== c_st_wake) begin n_fail++; $display("FAIL reset_release_state: got %b expected %b", state, c_st_wake); end
        n_checks++; if (en !== 1'b1) begin n_fail++; $display("FAIL reset_release_en: got %b expected 1", en); end
        go_off();
    endtask

    task automatic test_wake_latency();
        req = 4'b0001;
        cycle();
        n_checks++; if (en !== 1'b1) begin n_fail++; $display("FAIL wake_en: got %b expected 1", en); end
        n_checks++; if (state !== c_st_wake || ack !== 4'b0000) begin n_fail++; $display("FAIL wake_first: state %b ack %b expected %b 0000", state, ack, c_st_wake); end
        cycle();
        n_checks++; if (state !== c_st_wake || ack !== 4'b0000) begin n_fail++; $display("FAIL wake_second: state %b ack %b expected %b 0000", state, ack, c_st_wake); end
        cycle();
        n_checks++; if (state !== c_st_on) begin n_fail++; $display("FAIL wake_on_state: got %b expected %b", state, c_st_on); end
        n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL wake_ack: got %b expected 0001", ack); end
    endtask

    task automatic test_hysteresis();
        hyst_val = 8'd5; req = 4'b0000;
        for (int i = 1; i <= 5; i++) begin
            cycle();
            if (i == 2) hyst_val = 8'd1;
            n_checks++; if (state !== c_st_idle || en !== 1'b1) begin n_fail++; $display("FAIL hyst_idle%0d: state %b en %b expected %b 1", i, state, en, c_st_idle); end
        end
        cycle();
        n_checks++; if (state !== c_st_off || en !== 1'b0) begin n_fail++; $display("FAIL hyst_off: state %b en %b expected %b 0", state, en, c_st_off); end
        req = 4'b0001;
        repeat (3) cycle();
        n_checks++; if (state !== c_st_on) begin n_fail++; $display("FAIL hyst_reon: got %b expected %b", state, c_st_on); end
        hyst_val = 8'd0; req = 4'b0000;
        cycle();
        n_checks++; if (en !== 1'b0 || state !== c_st_off) begin n_fail++; $display("FAIL hyst_zero: en %b state %b expected 0 %b", en, state, c_st_off); end
    endtask

    task automatic test_rereq_idle();
        req = 4'b0001;
        repeat (3) cycle();
        hyst_val = 8'd5; req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++; if (en !== 1'b1) begin n_fail++; $display("FAIL rereq_en%0d: got %b expected 1", i, en); end
        end
        req = 4'b0100; #1;
        n_checks++; if (state !== c_st_idle || ack !== 4'b0000) begin n_fail++; $display("FAIL rereq_idle: state %b ack %b expected %b 0000", state, ack, c_st_idle); end
        cycle();
        n_checks++; if (state !== c_st_on || ack !== 4'b0100 || en !== 1'b1) begin n_fail++; $display("FAIL rereq_on: state %b ack %b en %b expected %b 0100 1", state, ack, en, c_st_on); end
        hyst_val = 8'd2; req = 4'b0000;
        cycle(); cycle();
        n_checks++; if (state !== c_st_idle) begin n_fail++; $display("FAIL rereq_tie_idle: got %b expected %b", state, c_st_idle); end
        req = 4'b0100;
        cycle();
        n_checks++; if (state !== c_st_on || ack !== 4'b0100) begin n_fail++; $display("FAIL rereq_tie_on: state %b ack %b expected %b 0100", state, ack, c_st_on); end
        go_off();
    endtask

    task automatic test_saturation();
        force_on = 1'b1; clr_cnt = 1'b1;
        cycle();
        clr_cnt = 1'b0;
        n_checks++; if (on_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_clr0: got %0d expected 0", on_cnt); end
        repeat (20) cycle();
        n_checks++; if (on_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_top: got %0d expected 15", on_cnt); end
        clr_cnt = 1'b1;
        cycle();
        clr_cnt = 1'b0;
        n_checks++; if (on_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_clr: got %0d expected 0", on_cnt); end
        cycle();
        n_checks++; if (on_cnt !== 4'd1) begin n_fail++; $display("FAIL sat_cnt1: got %0d expected 1", on_cnt); end
        cycle();
        n_checks++; if (on_cnt !== 4'd2) begin n_fail++; $display("FAIL sat_cnt2: got %0d expected 2", on_cnt); end
        go_off();
    endtask

    task automatic test_reset_mid_on();
        scan_te = 1'b1; req = 4'b1111;
        repeat (3) cycle();
        n_checks++; if (state !== c_st_on || ack !== 4'b1111) begin n_fail++; $display("FAIL midrst_on: state %b ack %b expected %b 1111", state, ack, c_st_on); end
        rn = 1'b0;
        cycle();
        n_checks++; if (en !== 1'b0 || ack !== 4'b0000 || state !== c_st_off) begin n_fail++; $display("FAIL midrst_drop: en %b ack %b state %b expected 0 0000 %b", en, ack, state, c_st_off); end
        n_checks++; if (te !== 1'b1) begin n_fail++; $display("FAIL midrst_te: got %b expected 1", te); end
        rn = 1'b1; scan_te = 1'b0;
        go_off();
    endtask

    task automatic test_random();
        logic [1:0]       es;
        logic [N_REQ-1:0] ea;
        for (int i = 0; i < 400; i++) begin
            rn       = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 3) == 0) req = N_REQ'($urandom);
            force_on = ($urandom_range(0, 9) == 0);
            hyst_val = HYST_W'($urandom_range(0, 6));
            clr_cnt  = ($urandom_range(0, 19) == 0);
            scan_te  = 1'($urandom);
            cycle();
            es = exp_state();
            ea = (es == c_st_on) ? req : '0;
            n_checks++; if (state !== es) begin n_fail++; $display("FAIL rand_state[%0d]: got %b expected %b", i, state, es); end
            n_checks++; if (en !== (es != c_st_off)) begin n_fail++; $display("FAIL rand_en[%0d]: got %b expected %b", i, en, es != c_st_off); end
            n_checks++; if (ack !== ea) begin n_fail++; $display("FAIL rand_ack[%0d]: got %b expected %b", i, ack, ea); end
            n_checks++; if (int'(on_cnt) !== m_cnt) begin n_fail++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", i, on_cnt, m_cnt); end
            n_checks++; if (te !== scan_te) begin n_fail++; $display("FAIL rand_te[%0d]: got %b expected %b", i, te, scan_te); end
        end
    endtask

    initial begin
        test_reset();
        test_wake_latency();
        test_hysteresis();
        test_rereq_idle();
        test_saturation();
        test_reset_mid_on();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/icg_enable_ctrl.md
# icg_enable_ctrl

Sequencing controller for a positive-edge integrated clock-gate cell with test enable (E/TE/CLK/Q). It shares one gated clock domain between several requesters and drives the gate's E input. A clock-stabilisation wake period precedes the acknowledge, and a programmable idle hysteresis prevents rapid gate toggling. It sits in the always-on CLK domain beside the ICG instance and also accumulates an enabled-cycle count for power reporting.

## Interface
- N_REQ, 4: number of requesters (≥1)
- HYST_W, 8: width of idle hysteresis count
- WAKE_CYC, 2: cycles of E-high before ack (≥1, ≤2^HYST_W−1)
- CNT_W, 16: width of enabled-cycle counter

Ports:
- CLK  in  1  free-running clock; all state updates on rising edge
- RN  in  1  reset, synchronous, active-low
- req  in  N_REQ  per-requester gated-clock request, level
- force_on  in  1  treat as an extra always-winning request
- hyst_val  in  HYST_W  idle cycles to hold E after last request drops; sampled on ON→IDLE
- scan_te  in  1  scan test enable
- clr_cnt  in  1  synchronous clear of on_cnt
- en  out  1  to ICG E; registered
- te  out  1  to ICG TE; equals scan_te (combinational)
- ack  out  N_REQ  gated clock running for requester i
- state  out  2  current FSM state
- on_cnt  out  CNT_W  saturating count of cycles with en=1

## Operation
- any_req = |req | force_on.
- States: OFF(00), WAKE(01), ON(10), IDLE(11). en = (state != OFF), decoded from the state register. No combinational path from inputs to en.
- OFF: any_req → WAKE, timer ← WAKE_CYC. Otherwise stay.
- WAKE: timer decrements each cycle. When timer==1, go to ON regardless of req. A request dropping during WAKE does not abort WAKE; it completes and the ON rules then apply.
- ON: !any_req → if hyst_val==0 go to OFF, else go to IDLE with timer ← hyst_val. Otherwise stay.
- IDLE: any_req → ON, and the timer is discarded. Else if timer==1 → OFF. Else decrement.
- ack[i] = req[i] & (state==ON). ack is derived from registered state, so it deasserts in the same cycle req[i] drops.
- te = scan_te and does not affect the FSM. With scan_te=1 the ICG output toggles regardless of en.
- on_cnt: clr_cnt=1 → 0. Else if en=1 and on_cnt != all-ones → +1. Saturates at 2^CNT_W−1. clr_cnt has priority over increment.
- Reset (RN=0 at edge): state=OFF, timer=0, on_cnt=0. Hence en=0 and ack=0 from the following cycle. Reset mid-WAKE/ON/IDLE drops en on that edge, with no hysteresis.

## Timing
- Req→ack latency from OFF: req first high at edge t; WAKE for cycles t+1..t+WAKE_CYC; ON and ack at t+WAKE_CYC+1. en is high from t+1.
- Req in IDLE: ON at the next edge and ack one cycle after req. No wake period, because the clock never stopped.
- Release: last any_req high at cycle t in ON. IDLE spans t+1..t+hyst_val. en falls at t+hyst_val+1. With hyst_val=0, en falls at t+1.
- hyst_val changes while in IDLE do not affect the running timer.
- Simultaneous req rise and timer==1 in IDLE: req wins, go to ON.
- en changes only on rising CLK, while CLK is high. The ICG latch is transparent when CLK is low, so Q is glitch-free.

## Structure
- Package icg_ctrl_pkg: state enum (OFF/WAKE/ON/IDLE with the encodings above) and the encoding constants used by the bench.
- Single shared timer of width HYST_W serves both WAKE and IDLE.
- Sub-module icg_ctrl_sat_cnt: parameterised CNT_W saturating up-counter with sync clear and increment enable, used for on_cnt.

## Test plan
- Reset: RN=0 for 2 cycles with req=4'b1111 → en=0, ack=0, state=00, on_cnt=0. Release → WAKE on the next edge.
- Wake latency: WAKE_CYC=2, req[0] rises at cycle 10 → en=1 at cycle 11, ack[0]=1 at cycle 13, ack[1..3]=0.
- Hysteresis: hyst_val=5, req drops at cycle 20 in ON → IDLE during cycles 21–25, en=0 at 26. Repeat with hyst_val=0 → en=0 at 21.
- Re-request in IDLE: hyst_val=5, req[2] rises at the third IDLE cycle → state ON next cycle, ack[2]=1, en stays high throughout.
- Saturation/clear: CNT_W=4, force_on=1 for 20 cycles → on_cnt stops at 15. Assert clr_cnt with en=1 → on_cnt=0 next cycle, then counts 1, 2, …
- Reset mid-ON with scan_te=1 → en=0 and ack=0 next cycle, te stays 1.
